ce_gen_frac: RTL and testbench
==============================

# ce_gen_frac

Parametrised fractional clock-enable generator. It runs on the single core master clock and produces CHANNELS independent one-cycle enable strobes. Each strobe has a runtime-programmable ratio NUM/DEN and a phase offset. It replaces fixed-ratio, fixed-phase derived clocks (e.g. 96 → 32/8 MHz, 8 MHz with a quarter-period offset) with enables in one clock domain, and adds resynchronisation, config validation and a lock indication.

## Interface
Parameters:
- CHANNELS, 4, number of enable outputs (1..16)
- ACC_W, 16, width of NUM/DEN/PHASE fields
- LOCK_CYCLES, 256, cycles of stable config before `locked` asserts (≥1)

Ports:
- clk  in  1  master clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_wr  in  1  one-cycle config write strobe
- cfg_ch  in  $clog2(CHANNELS) (min 1)  target channel of write
- cfg_num  in  ACC_W  numerator, strobes per DEN master cycles
- cfg_den  in  ACC_W  denominator
- cfg_phase  in  ACC_W  initial accumulator value
- sync  in  1  restart all channels at their programmed phase
- ce  out  CHANNELS  per-channel enable strobe, registered
- locked  out  1  config stable for LOCK_CYCLES
- cfg_err  out  1  one-cycle pulse on a rejected write

## Operation
- Per channel, registers: num, den, phase (ACC_W), acc (ACC_W+1).
- Reset values:
  - num=0, den=1, phase=0, acc=0.
  - ce=0, locked=0, cfg_err=0, lock counter=0.
  - With num=0, no strobes are produced.
- Each cycle, per channel, with no load:
  - s = acc + num (ACC_W+1 bits, no overflow since acc<den, num≤den).
  - If s ≥ den: ce←1 and acc←s−den.
  - Otherwise: ce←0 and acc←s.
- Valid write requires den≠0, num≤den and phase<den. On a valid write, at the same edge:
  - the target channel's num/den/phase are loaded;
  - acc←cfg_phase and ce[ch]←0;
  - the lock counter clears and locked←0.
- Invalid write:
  - No register changes and the lock counter is unaffected.
  - cfg_err=1 for exactly one cycle.
- cfg_ch ≥ CHANNELS is treated as an invalid write.
- sync=1, at that edge:
  - every channel sets acc←phase and ce←0;
  - the lock counter clears and locked←0.
- sync together with a valid cfg_wr:
  - The target channel takes the new config with acc←cfg_phase.
  - All other channels resync.
  - The counter clears once.
- sync together with an invalid cfg_wr: sync applies and cfg_err pulses.
- Lock counter:
  - Increments every cycle with no clearing event and saturates at LOCK_CYCLES.
  - locked=1 while counter==LOCK_CYCLES.
- Long-term ce rate is exactly num/den of clk, with no drift. Strobe spacing is ⌊den/num⌋ or ⌈den/num⌉ cycles.

## Timing
- ce is registered. It reflects the compare on acc as it stood before the edge.
- After a load (write or sync) at edge E0, the first ce occurs at edge Ek, with k = smallest k≥1 such that phase + k·num ≥ den.
- num=den: ce=1 on every edge after E0.
- num=1, den=12, phase=0: ce at E12, E24, …
- Same ratio, phase=6: ce at E6, E18, ….
- locked rises at edge E0+LOCK_CYCLES after the last clearing event (reset release counts as E0).
- cfg_err is high during the cycle after the write edge only.
- Reset asserted mid-operation:
  - All outputs go to reset values immediately (asynchronous), and all configs revert.
  - After release, the first edge behaves as E0 with num=0.

## Test plan
- Reset, then hold 300 cycles with no writes:
  - ce=0 throughout.
  - locked=1 from edge 256 onward.
  - cfg_err never set.
- Write ch0 num=1 den=3 phase=0:
  - ce[0] at E3, E6, E9.
  - locked drops at E0 and rises at E256.
- Write ch1 num=3 den=8 phase=0, run 80 cycles: exactly 30 ce[1] pulses, spacing only 2 or 3.
- Write ch2 and ch3 num=1 den=12, phases 0 and 3, then pulse sync:
  - ce[2] at E12, E24.
  - ce[3] at E9, E21.
  - Both restart identically after a second sync.
- Write ch0 with den=0, then num=5 den=4, then phase=4 den=4:
  - cfg_err pulses three times.
  - ce[0] pattern unchanged.
  - locked stays high.
- Assert reset_n low mid-stream between clock edges:
  - ce, locked and cfg_err go to 0 before the next edge.
  - After release, no strobes until a new write.

Source files
------------

// File: rtl/ce_gen_frac.sv
// ce_gen_frac: fractional clock-enable generator.
// Produces CHANNELS one-cycle enable strobes in the master clock domain,
// each at a runtime-programmable rate NUM/DEN with a programmable start
// phase. Writes are validated, a common sync restarts every channel at its
// programmed phase, and a lock flag reports how long the config has been stable.
//
// Config interface: cfg_wr is a single-cycle strobe with no backpressure.
// The write is sampled at the rising edge where cfg_wr=1 and takes effect
// at that same edge. A rejected write changes no state and raises cfg_err
// for the following cycle only.
module ce_gen_frac #(
   parameter int CHANNELS    = 4,
   parameter int ACC_W       = 16,
   parameter int LOCK_CYCLES = 256
) (
   input  logic                                                clk,
   input  logic                                                reset_n,
   input  logic                                                cfg_wr,
   input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0]  cfg_ch,
   input  logic [ACC_W-1:0]                                    cfg_num,
   input  logic [ACC_W-1:0]                                    cfg_den,
   input  logic [ACC_W-1:0]                                    cfg_phase,
   input  logic                                                sync,
   output logic [CHANNELS-1:0]                                 ce,
   output logic                                                locked,
   output logic                                                cfg_err
);

   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int LK_W = $clog2(LOCK_CYCLES + 1);

   // Channel index limit, one bit wider than cfg_ch so that a non-power-of-two
   // channel count can reject indices beyond the last channel.
   localparam logic [CH_W:0]   CH_LIM = (CH_W + 1)'(CHANNELS);
   localparam logic [LK_W-1:0] LK_MAX = LK_W'(LOCK_CYCLES);

   // Per-channel programmed configuration
   logic [ACC_W-1:0] r_num   [CHANNELS];
   logic [ACC_W-1:0] r_den   [CHANNELS];
   logic [ACC_W-1:0] r_phase [CHANNELS];

   // Per-channel phase accumulator; one extra bit holds acc+num before the
   // wrap subtraction (acc < den and num <= den, so it never overflows).
   logic [ACC_W:0]   r_acc   [CHANNELS];

   logic [CHANNELS-1:0] r_ce;
   logic [LK_W-1:0]     r_lock_cnt;
   logic                r_locked;
   logic                r_cfg_err;

   logic                w_wr_ok;
   logic                w_clear;
   logic [LK_W-1:0]     w_cnt_inc;
   logic [ACC_W:0]      w_sum  [CHANNELS];
   logic [CHANNELS-1:0] w_hit;
   logic [CHANNELS-1:0] w_sel;

   // Write validation and the common "restart lock timing" event
   always_comb begin
      w_wr_ok = cfg_wr
             && (cfg_den != '0)
             && (cfg_num <= cfg_den)
             && (cfg_phase < cfg_den)
             && ({1'b0, cfg_ch} < CH_LIM);
      w_clear   = w_wr_ok || sync;
      w_cnt_inc = r_lock_cnt + LK_W'(1);
   end

   // Per-channel accumulate-and-compare and write target decode
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         w_sum[i] = r_acc[i] + {1'b0, r_num[i]};
         w_hit[i] = (w_sum[i] >= {1'b0, r_den[i]});
         w_sel[i] = w_wr_ok && (cfg_ch == CH_W'(i));
      end
   end

   // Configuration registers: only a validated write to the channel loads them
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_num[i]   <= '0;
            r_den[i]   <= ACC_W'(1);
            r_phase[i] <= '0;
         end
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_sel[i]) begin
               r_num[i]   <= cfg_num;
               r_den[i]   <= cfg_den;
               r_phase[i] <= cfg_phase;
            end
         end
      end
   end

   // Accumulators and strobes: a write to the channel wins over sync, and
   // sync wins over normal accumulation; both loads suppress the strobe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < CHANNELS; i++) begin
            r_acc[i] <= '0;
         end
         r_ce <= '0;
      end else begin
         for (int i = 0; i < CHANNELS; i++) begin
            if (w_sel[i]) begin
               r_acc[i] <= {1'b0, cfg_phase};
               r_ce[i]  <= 1'b0;
            end else if (sync) begin
               r_acc[i] <= {1'b0, r_phase[i]};
               r_ce[i]  <= 1'b0;
            end else if (w_hit[i]) begin
               r_acc[i] <= w_sum[i] - {1'b0, r_den[i]};
               r_ce[i]  <= 1'b1;
            end else begin
               r_acc[i] <= w_sum[i];
               r_ce[i]  <= 1'b0;
            end
         end
      end
   end

   // Lock counter: restarts on any accepted load, saturates at LOCK_CYCLES
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (w_clear) begin
         r_lock_cnt <= '0;
         r_locked   <= 1'b0;
      end else if (r_lock_cnt != LK_MAX) begin
         r_lock_cnt <= w_cnt_inc;
         r_locked   <= (w_cnt_inc == LK_MAX);
      end else begin
         r_locked   <= 1'b1;
      end
   end

   // Rejected-write pulse, high for the one cycle after the write edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cfg_err <= 1'b0;
      end else begin
         r_cfg_err <= cfg_wr && !w_wr_ok;
      end
   end

   assign ce      = r_ce;
   assign locked  = r_locked;
   assign cfg_err = r_cfg_err;

endmodule

// File: tb/tb_ce_gen_frac.sv
// Testbench for ce_gen_frac: directed scenarios with hand-computed strobe
// positions, followed by randomized config/sync traffic, all shadowed by a
// per-cycle reference model based on floor((phase + t*num)/den) counting.
module tb_ce_gen_frac;

   localparam int CH = 5;
   localparam int AW = 16;
   localparam int LK = 256;
   localparam int W  = CH + 2;

   // ---------------- clock / reset ----------------
   logic          clk       = 1'b0;
   logic          reset_n   = 1'b0;
   logic          cfg_wr    = 1'b0;
   logic [2:0]    cfg_ch    = '0;
   logic [AW-1:0] cfg_num   = '0;
   logic [AW-1:0] cfg_den   = '0;
   logic [AW-1:0] cfg_phase = '0;
   logic          sync      = 1'b0;
   logic [CH-1:0] ce;
   logic          locked;
   logic          cfg_err;

   always #5 clk = ~clk;

   ce_gen_frac #(
      .CHANNELS   (CH),
      .ACC_W      (AW),
      .LOCK_CYCLES(LK)
   ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .cfg_wr   (cfg_wr),
      .cfg_ch   (cfg_ch),
      .cfg_num  (cfg_num),
      .cfg_den  (cfg_den),
      .cfg_phase(cfg_phase),
      .sync     (sync),
      .ce       (ce),
      .locked   (locked),
      .cfg_err  (cfg_err)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   // Channel strobes at edge t after a load iff floor((phase+t*num)/den)
   // increments between t-1 and t.
   longint m_num   [CH];
   longint m_den   [CH];
   longint m_phase [CH];
   longint m_t     [CH];
   int     m_cnt;
   logic [W-1:0] exp_q[$];

   always @(posedge clk or negedge reset_n) begin
      logic [W-1:0] v;
      bit ok;
      if (!reset_n) begin
         for (int i = 0; i < CH; i++) begin
            m_num[i] = 0; m_den[i] = 1; m_phase[i] = 0; m_t[i] = 0;
         end
         m_cnt = 0;
         exp_q.delete();
         exp_q.push_back('0);
      end else begin
         ok = cfg_wr && (cfg_den != 0) && (cfg_num <= cfg_den) &&
              (cfg_phase < cfg_den) && (int'(cfg_ch) < CH);
         v = '0;
         for (int i = 0; i < CH; i++) begin
            if (ok && int'(cfg_ch) == i) begin
               m_num[i] = longint'(cfg_num);
               m_den[i] = longint'(cfg_den);
               m_phase[i] = longint'(cfg_phase);
               m_t[i] = 0;
            end else if (sync) begin
               m_t[i] = 0;
            end else begin
               m_t[i] = m_t[i] + 1;
               if ((m_phase[i] + m_t[i] * m_num[i]) / m_den[i] !=
                   (m_phase[i] + (m_t[i] - 1) * m_num[i]) / m_den[i])
                  v[i] = 1'b1;
            end
         end
         if (ok || sync) m_cnt = 0;
         else if (m_cnt < LK) m_cnt = m_cnt + 1;
         v[CH]     = (m_cnt == LK);
         v[CH + 1] = cfg_wr && !ok;
         exp_q.push_back(v);
      end
   end

   // ---------------- scoreboard: every cycle ----------------
   always @(negedge clk) begin
      logic [W-1:0] e;
      logic [W-1:0] g;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {cfg_err, locked, ce};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL cycle_cmp t=%0t got={err,lock,ce}=%b exp=%b", $time, g, e);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_cfg(input int ch, input int num, input int den, input int ph,
                            input bit with_sync);
      cfg_ch    = 3'(ch);
      cfg_num   = AW'(num);
      cfg_den   = AW'(den);
      cfg_phase = AW'(ph);
      cfg_wr    = 1'b1;
      sync      = with_sync;
      tick();
      cfg_wr    = 1'b0;
      sync      = 1'b0;
   endtask

   task automatic do_sync();
      sync = 1'b1;
      tick();
      sync = 1'b0;
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [CH-1:0] ce_or;
      logic          err_or;
      int n, last, gap_bad;
      int inv [3][3];

      // Reset and idle
      reset_n = 1'b0;
      repeat (3) tick();
      check("reset_ce", 32'(ce), 0);
      check("reset_locked", 32'(locked), 0);
      reset_n = 1'b1;
      ce_or = '0; err_or = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         ce_or  = ce_or | ce;
         err_or = err_or | cfg_err;
         if (k == 255) check("idle_lock_255", 32'(locked), 0);
         if (k == 256) check("idle_lock_256", 32'(locked), 1);
      end
      check("idle_ce_none", 32'(ce_or), 0);
      check("idle_err_none", 32'(err_or), 0);
      check("idle_lock_300", 32'(locked), 1);

      // ch0 = 1/3, phase 0
      write_cfg(0, 1, 3, 0, 1'b0);
      check("wr0_lock_drop", 32'(locked), 0);
      for (int k = 1; k <= 256; k++) begin
         tick();
         if (k <= 9) check($sformatf("ch0_ce_E%0d", k), 32'(ce[0]), 32'(k % 3 == 0));
         if (k == 255) check("wr0_lock_255", 32'(locked), 0);
         if (k == 256) check("wr0_lock_256", 32'(locked), 1);
      end

      // ch1 = 3/8 over 80 cycles
      write_cfg(1, 3, 8, 0, 1'b0);
      n = 0; last = 0; gap_bad = 0;
      for (int k = 1; k <= 80; k++) begin
         tick();
         if (ce[1]) begin
            if (n > 0 && (k - last < 2 || k - last > 3)) gap_bad++;
            n++;
            last = k;
         end
      end
      check("ch1_pulses_80", 32'(n), 30);
      check("ch1_gap_bad", 32'(gap_bad), 0);

      // ch2/ch3 = 1/12, phases 0 and 3, restarted by sync twice
      write_cfg(2, 1, 12, 0, 1'b0);
      write_cfg(3, 1, 12, 3, 1'b0);
      do_sync();
      for (int rep = 0; rep < 2; rep++) begin
         for (int k = 1; k <= 24; k++) begin
            tick();
            check($sformatf("sync%0d_ch2_E%0d", rep, k), 32'(ce[2]), 32'(k % 12 == 0));
            check($sformatf("sync%0d_ch3_E%0d", rep, k), 32'(ce[3]), 32'(k == 9 || k == 21));
         end
         if (rep == 0) do_sync();
      end

      // Rejected writes while locked
      repeat (260) tick();
      check("pre_inv_locked", 32'(locked), 1);
      inv = '{'{1, 0, 0}, '{5, 4, 0}, '{1, 4, 4}};
      for (int j = 0; j < 3; j++) begin
         write_cfg(0, inv[j][0], inv[j][1], inv[j][2], 1'b0);
         check($sformatf("inv%0d_err", j), 32'(cfg_err), 1);
         check($sformatf("inv%0d_locked", j), 32'(locked), 1);
         tick();
         check($sformatf("inv%0d_err_clear", j), 32'(cfg_err), 0);
      end
      write_cfg(6, 1, 2, 0, 1'b0);
      check("inv_ch_err", 32'(cfg_err), 1);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (ce[0]) n++;
      end
      check("ch0_rate_after_inv", 32'(n), 10);
      check("inv_locked_kept", 32'(locked), 1);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         int r, den, num, ph;
         r = $urandom_range(0, 99);
         if (r < 6 || r == 11) begin
            den = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 65535) : $urandom_range(1, 20);
            num = $urandom_range(0, den);
            ph  = $urandom_range(0, den - 1);
            write_cfg($urandom_range(0, CH - 1), num, den, ph, r == 11);
         end else if (r < 9) begin
            write_cfg($urandom_range(0, 7), $urandom_range(0, 20), $urandom_range(0, 20),
                      $urandom_range(0, 20), $urandom_range(0, 1) == 1);
         end else if (r < 11) begin
            do_sync();
         end else begin
            tick();
         end
      end

      // Asynchronous reset mid-cycle
      write_cfg(0, 1, 1, 0, 1'b0);
      repeat (260) tick();
      write_cfg(0, 0, 0, 0, 1'b0);
      check("pre_rst_ce0", 32'(ce[0]), 1);
      check("pre_rst_locked", 32'(locked), 1);
      check("pre_rst_err", 32'(cfg_err), 1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_ce", 32'(ce), 0);
      check("rst_locked", 32'(locked), 0);
      check("rst_err", 32'(cfg_err), 0);
      repeat (2) tick();
      reset_n = 1'b1;
      ce_or = '0;
      for (int k = 0; k < 50; k++) begin
         tick();
         ce_or = ce_or | ce;
      end
      check("post_rst_ce_none", 32'(ce_or), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
